// File: rtl/agen_pkg.sv
// Shared encodings and helpers for the address generation stage.
package agen_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned SIZE_W = 3;
    localparam int unsigned STK_W  = 2;

    localparam logic [SIZE_W-1:0] SIZE_NONE = 3'd0;
    localparam logic [SIZE_W-1:0] SIZE_8    = 3'd1;
    localparam logic [SIZE_W-1:0] SIZE_16   = 3'd2;
    localparam logic [SIZE_W-1:0] SIZE_32   = 3'd3;
    localparam logic [SIZE_W-1:0] SIZE_48   = 3'd4;
    localparam logic [SIZE_W-1:0] SIZE_64   = 3'd5;

    localparam logic [STK_W-1:0] STACK_NONE = 2'b00;
    localparam logic [STK_W-1:0] STACK_PUSH = 2'b01;
    localparam logic [STK_W-1:0] STACK_POP  = 2'b10;

    // Bytes moved by a stack access (also the span used for limit checks).
    function automatic logic [3:0] stack_bytes(input logic [SIZE_W-1:0] size);
        case (size)
            SIZE_16: return 4'd2;
            SIZE_64: return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/agen_ea_adder.sv
// Effective address: seg_base + base + (index << scale) + disp, modulo 2^32.
module agen_ea_adder
    import agen_pkg::*;
(
    input  logic [ADDR_W-1:0] seg_base,
    input  logic [ADDR_W-1:0] base,
    input  logic              base_valid,
    input  logic [ADDR_W-1:0] index,
    input  logic              index_valid,
    input  logic [1:0]        scale,
    input  logic [ADDR_W-1:0] disp,
    output logic [ADDR_W-1:0] ea_c
);

    logic [ADDR_W-1:0] base_term_c;
    logic [ADDR_W-1:0] index_term_c;

    always_comb begin
        base_term_c  = base_valid  ? base : '0;
        index_term_c = index_valid ? (index << scale) : '0;
        ea_c         = seg_base + base_term_c + index_term_c + disp;
    end

endmodule

// File: rtl/address_generation_top.sv
// Address generation stage: EA compute, shadow ESP tracking, hazard stall, one-deep output register.
// Optional segment limit fault checking is built when AGEN_SEG_LIMIT_EN is defined.
module address_generation_top
    import agen_pkg::*;
#(
    parameter int unsigned PASSW = 160
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               d_valid,
    output logic               d_ready,
    input  logic [2:0]         d_size,
    input  logic [63:0]        d_op0,
    input  logic [63:0]        d_op1,
    input  logic               d_op0_is_address,
    input  logic               d_op1_is_address,
    input  logic [2:0]         d_base_reg,
    input  logic [2:0]         d_index_reg,
    input  logic               d_base_valid,
    input  logic               d_index_valid,
    input  logic [1:0]         d_scale,
    input  logic [31:0]        d_disp,
    input  logic [2:0]         d_seg_reg,
    input  logic [1:0]         d_stack_op,
    input  logic [PASSW-1:0]   d_sideband,
    output logic [2:0]         rf_rd0_reg,
    output logic [2:0]         rf_rd1_reg,
    input  logic [31:0]        rf_rd0_data,
    input  logic [31:0]        rf_rd1_data,
    input  logic [7:0]         rf_busy,
    output logic [2:0]         seg_rd_reg,
    input  logic [31:0]        seg_rd_base,
    input  logic [31:0]        seg_rd_limit,
    input  logic [31:0]        esp_commit,
    output logic               a_valid,
    input  logic               a_ready,
    output logic [2:0]         a_size,
    output logic [63:0]        a_op0,
    output logic [63:0]        a_op1,
    output logic               a_op0_is_address,
    output logic               a_op1_is_address,
    output logic [1:0]         a_stack_op,
    output logic [31:0]        a_stack_address,
    output logic [PASSW-1:0]   a_sideband,
    output logic               a_fault
);

    logic [ADDR_W-1:0] ea_c;
    logic [ADDR_W-1:0] shadow_esp;
    logic [ADDR_W-1:0] bytes_c;
    logic [ADDR_W-1:0] stack_addr_c;
    logic [ADDR_W-1:0] shadow_next_c;
    logic [DATA_W-1:0] op0_c;
    logic [DATA_W-1:0] op1_c;
    logic              stall_c;
    logic              accept_c;

    assign rf_rd0_reg = d_base_reg;
    assign rf_rd1_reg = d_index_reg;
    assign seg_rd_reg = d_seg_reg;

    agen_ea_adder u_ea_adder (
        .seg_base    (seg_rd_base),
        .base        (rf_rd0_data),
        .base_valid  (d_base_valid),
        .index       (rf_rd1_data),
        .index_valid (d_index_valid),
        .scale       (d_scale),
        .disp        (d_disp),
        .ea_c        (ea_c)
    );

    // Handshake and RAW hazard on base/index registers.
    always_comb begin
        stall_c  = (d_base_valid & rf_busy[d_base_reg]) | (d_index_valid & rf_busy[d_index_reg]);
        d_ready  = ~stall_c & (~a_valid | a_ready);
        accept_c = d_valid & d_ready;
    end

    // Operand muxing and shadow stack pointer arithmetic.
    always_comb begin
        op0_c         = d_op0_is_address ? {32'h0, ea_c} : d_op0;
        op1_c         = (d_op1_is_address & ~d_op0_is_address) ? {32'h0, ea_c} : d_op1;
        bytes_c       = ADDR_W'(stack_bytes(d_size));
        stack_addr_c  = shadow_esp;
        shadow_next_c = shadow_esp;
        case (d_stack_op)
            STACK_PUSH: begin
                stack_addr_c  = shadow_esp - bytes_c;
                shadow_next_c = shadow_esp - bytes_c;
            end
            STACK_POP: shadow_next_c = shadow_esp + bytes_c;
            default: ;
        endcase
    end

    // Output register; flush wins over a same-cycle accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_valid          <= 1'b0;
            a_size           <= '0;
            a_op0            <= '0;
            a_op1            <= '0;
            a_op0_is_address <= 1'b0;
            a_op1_is_address <= 1'b0;
            a_stack_op       <= '0;
            a_stack_address  <= '0;
            a_sideband       <= '0;
            shadow_esp       <= '0;
        end else if (flush) begin
            a_valid    <= 1'b0;
            shadow_esp <= esp_commit;
        end else if (accept_c) begin
            a_valid          <= 1'b1;
            a_size           <= d_size;
            a_op0            <= op0_c;
            a_op1            <= op1_c;
            a_op0_is_address <= d_op0_is_address;
            a_op1_is_address <= d_op1_is_address;
            a_stack_op       <= d_stack_op;
            a_stack_address  <= stack_addr_c;
            a_sideband       <= d_sideband;
            shadow_esp       <= shadow_next_c;
        end else if (a_ready) begin
            a_valid <= 1'b0;
        end
    end

`ifdef AGEN_SEG_LIMIT_EN
    logic [ADDR_W-1:0] seg_off_c;
    logic [ADDR_W:0]   seg_end_c;
    logic              fault_c;

    // Last byte touched, relative to the segment base, against the limit.
    always_comb begin
        seg_off_c = ea_c - seg_rd_base;
        seg_end_c = (ADDR_W+1)'(seg_off_c) + (ADDR_W+1)'(bytes_c) - (ADDR_W+1)'(1);
        fault_c   = (d_op0_is_address | d_op1_is_address) & (seg_end_c > (ADDR_W+1)'(seg_rd_limit));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_fault <= 1'b0;
        end else if (!flush && accept_c) begin
            a_fault <= fault_c;
        end
    end
`else
    logic unused_limit;

    assign a_fault      = 1'b0;
    assign unused_limit = ^seg_rd_limit;
`endif

endmodule

// File: doc/address_generation_top.md
# address_generation_top

Pipeline stage directly upstream of the memory read stage. Accepts decoded instructions, reads base/index registers and segment base, computes the linear address `seg_base + base + (index << scale) + disp`, and maintains a speculative shadow stack pointer for push/pop. Presents one registered transaction per handshake on the `a_*` channel consumed by memory read. It stalls on pending register writes to base or index.

## Interface
- PASSW, 160, width of sideband bundle passed through unmodified (d flags, alu_op, flags, pc, branch_taken, to_sys_controller, opcode, imm, regs)
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  discard staged transaction, resync shadow ESP
- d_valid / d_ready  in/out  1  decode handshake
- d_size  in  3  operand size: 1=8b, 2=16b, 3=32b, 4=48b, 5=64b, 0/6/7 none
- d_op0, d_op1  in  64  non-address operand values
- d_op0_is_address, d_op1_is_address  in  1  operand is memory
- d_base_reg, d_index_reg  in  3  GPR numbers; d_base_valid, d_index_valid  in  1
- d_scale  in  2  index shift 0..3
- d_disp  in  32  displacement
- d_seg_reg  in  3  segment selector index
- d_stack_op  in  2  01=push, 10=pop, 00/11=none
- d_sideband  in  PASSW  pass-through
- rf_rd0_reg, rf_rd1_reg  out  3  base/index read addresses; rf_rd0_data, rf_rd1_data  in  32
- rf_busy  in  8  per-GPR pending-write mask
- seg_rd_reg  out  3; seg_rd_base  in  32; seg_rd_limit  in  32
- esp_commit  in  32  architectural ESP from write back
- a_valid / a_ready  out/in  1  memory-read handshake
- a_size out 3; a_op0, a_op1 out 64; a_op0_is_address, a_op1_is_address out 1; a_stack_op out 2; a_stack_address out 32; a_sideband out PASSW; a_fault out 1

## Operation
- Read ports are combinational: rf_rd0_reg=d_base_reg, rf_rd1_reg=d_index_reg, seg_rd_reg=d_seg_reg.
- EA = seg_rd_base + (base_valid?rf_rd0_data:0) + (index_valid?rf_rd1_data<<d_scale:0) + d_disp, modulo 2^32; carries discarded.
- a_op0 = {32'h0, EA} when d_op0_is_address, else d_op0. a_op1 = {32'h0, EA} when d_op1_is_address and not d_op0_is_address, else d_op1. Both address flags pass through unchanged.
- Stack byte count: size 2→2, size 5→8, otherwise 4.
- Push: new = shadow_esp − bytes; a_stack_address = new; shadow_esp ← new on accept.
- Pop: a_stack_address = shadow_esp; shadow_esp ← shadow_esp + bytes on accept.
- None: a_stack_address = shadow_esp; shadow_esp is unchanged.
- Hazard stall: `stall = (base_valid & rf_busy[base]) | (index_valid & rf_busy[index])`.
- d_ready = ~stall & (~a_valid | a_ready).
- Accept = d_valid & d_ready; loads the output register. a_valid clears when a_ready is high and nothing is accepted.
- Flush: a_valid←0, shadow_esp←esp_commit, and any same-cycle accept is dropped. Flush overrides accept.

## Timing
- Latency 1 cycle from accept to a_valid. Full throughput, one per cycle, when a_ready is held high.
- a_* data is stable while a_valid & ~a_ready.
- Reset (reset=0, asynchronous): a_valid=0, all a_* data=0, a_fault=0, shadow_esp=0.
- First accept after reset deassertion is permitted the same cycle.
- Shadow ESP wraps modulo 2^32. Push at 0x00000002 with bytes=4 yields 0xFFFFFFFE.
- Stall asserted mid-backpressure: the staged output is held and no new accept occurs.

## Configuration
- AGEN_SEG_LIMIT_EN defined:
  - For an accepted memory operand, a_fault=1 when (EA − seg_rd_base) + bytes − 1 > seg_rd_limit, using unsigned 33-bit compare. Bytes use the stack byte-count rule.
  - a_valid still asserts; the fault is registered with the transaction.
- AGEN_SEG_LIMIT_EN undefined: a_fault is tied to 0 and no compare logic is built.

## Structure
- Package agen_pkg holds:
  - size encodings and stack_op codes (PUSH=2'b01, POP=2'b10)
  - the size→byte-count function
- One sub-module, agen_ea_adder: scaled index shift plus 4-input 32-bit sum. The top level keeps the shadow ESP, hazard logic and output register.

## Test plan
- Address calculation: base=0x1000, index=0x10, scale=2, disp=0x8, seg_base=0x20000, op0 address → a_op0=0x21048, a_valid one cycle after accept.
- Push sequence: shadow_esp=0x100, push size 3 then push size 2 back-to-back → a_stack_address 0xFC then 0xFA, shadow_esp=0xFA.
- Pop: pop size 5 at shadow_esp=0x200 → a_stack_address 0x200, shadow_esp=0x208.
- Hazard and backpressure: rf_busy[base]=1 → d_ready=0 until cleared. Then with a_ready=0 for 3 cycles → a_* held constant and d_ready=0.
- Flush with concurrent d_valid, esp_commit=0x7FF0 → a_valid=0 next cycle, shadow_esp=0x7FF0, and the next push yields 0x7FEC.
- Limit fault (with AGEN_SEG_LIMIT_EN): seg_limit=0xFFF, offset 0xFFE, size 3 → a_fault=1; offset 0xFFC → a_fault=0. Asynchronous reset mid-stream → a_valid=0 immediately.
